xext_bridge: RTL and testbench

- Responder for the external-port slot of the picoversat address decoder; consumes ext_sel and returns ext_data_to_rd.
- Converts single-cycle controller accesses into a req/ack handshake on an external bus.
- Returns a ready pulse so the controller can stall on slow targets.
- A timeout counter guarantees completion when the external target never acknowledges.

---
 rtl/xext_bridge_pkg.sv | 14 +
 rtl/xext_bridge_timeout.sv | 26 ++
 rtl/xext_bridge.sv | 108 ++++++++++
 tb/tb_xext_bridge.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/xext_bridge_pkg.sv
// Shared definitions for the external-port bridge: FSM encodings and defaults.
package xext_bridge_pkg;

    typedef logic [1:0] ext_state_t;

    // Legacy-compatible state encodings
    localparam ext_state_t EXT_IDLE = 2'd0;
    localparam ext_state_t EXT_BUSY = 2'd1;
    localparam ext_state_t EXT_DONE = 2'd2;

    localparam int EXT_ADDR_W_DEF  = 10;
    localparam int EXT_TIMEOUT_DEF = 255;

endpackage

// File: rtl/xext_bridge_timeout.sv
// Saturating wait counter: clears on a new request, counts while enabled,
// flags when it reaches TIMEOUT and then holds there.
module xext_timeout #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [TO_W-1:0] r_cnt;

    assign hit = (r_cnt == TO_W'(TIMEOUT));

    // Count up while enabled, stop at TIMEOUT so the counter never wraps
    always_ff @(posedge clk) begin
        if (rst || clr)
            r_cnt <= '0;
        else if (en && !hit)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/xext_bridge.sv
// External-port responder: turns a single-cycle controller access into a
// req/ack handshake, returns a one-cycle ready pulse, and forces completion
// with a sticky error flag if the target never acknowledges.
module xext_bridge
    import xext_bridge_pkg::*;
#(
    parameter int EXT_ADDR_W = EXT_ADDR_W_DEF,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = EXT_TIMEOUT_DEF,
    parameter int TO_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel,
    input  logic                  we,
    input  logic [EXT_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  ready,
    output logic                  err,
    input  logic                  err_clr,
    output logic                  ext_req,
    output logic                  ext_we,
    output logic [EXT_ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0]     ext_wdata,
    input  logic [DATA_W-1:0]     ext_rdata,
    input  logic                  ext_ack
);

    ext_state_t              r_state;
    logic                    r_req;
    logic                    r_we;
    logic [EXT_ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic [DATA_W-1:0]       r_data_out;
    logic                    r_err;

    logic                    w_start;
    logic                    w_busy;
    logic                    w_hit;

    assign w_start = (r_state == EXT_IDLE) && sel;
    assign w_busy  = (r_state == EXT_BUSY);

    xext_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (w_start),
        .en  (w_busy),
        .hit (w_hit)
    );

    // Handshake FSM; ack is checked before timeout so a same-cycle ack wins,
    // and err_clr is applied first so a same-cycle timeout set overrides it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EXT_IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_data_out <= '0;
            r_err      <= 1'b0;
        end else begin
            if (err_clr)
                r_err <= 1'b0;
            case (r_state)
                EXT_IDLE: begin
                    if (sel) begin
                        r_we    <= we;
                        r_addr  <= addr;
                        r_wdata <= data_in;
                        r_req   <= 1'b1;
                        r_state <= EXT_BUSY;
                    end
                end
                EXT_BUSY: begin
                    if (ext_ack) begin
                        r_req <= 1'b0;
                        if (!r_we)
                            r_data_out <= ext_rdata;
                        r_state <= EXT_DONE;
                    end else if (w_hit) begin
                        r_req <= 1'b0;
                        r_err <= 1'b1;
                        if (!r_we)
                            r_data_out <= '0;
                        r_state <= EXT_DONE;
                    end
                end
                EXT_DONE: r_state <= EXT_IDLE;
                default:  r_state <= EXT_IDLE;
            endcase
        end
    end

    assign ready     = (r_state == EXT_DONE);
    assign data_out  = r_data_out;
    assign err       = r_err;
    assign ext_req   = r_req;
    assign ext_we    = r_we;
    assign ext_addr  = r_addr;
    assign ext_wdata = r_wdata;

endmodule

// File: tb/tb_xext_bridge.sv
// Directed bench for xext_bridge with a short timeout window.
module tb_xext_bridge;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst, sel, we, err_clr, ext_ack;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in, ext_rdata;
    logic [DW-1:0] data_out, ext_wdata;
    logic [AW-1:0] ext_addr;
    logic          ready, err, ext_req, ext_we;

    int total = 0;
    int bad   = 0;
    int n_ready = 0;
    int n_rise  = 0;
    logic prev_req = 1'b0;

    always #5 clk = ~clk;

    xext_bridge #(.EXT_ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TO_W(3)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .data_in(data_in),
        .data_out(data_out), .ready(ready), .err(err), .err_clr(err_clr),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack)
    );

    // Event counters sampled mid-cycle
    always @(negedge clk) begin
        if (ready) n_ready++;
        if (ext_req && !prev_req) n_rise++;
        prev_req = ext_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int r0, q0;

    initial begin
        rst = 1; sel = 0; we = 0; err_clr = 0; ext_ack = 0;
        addr = '0; data_in = '0; ext_rdata = '0;
        tick(); tick();
        rst = 0;
        chk("rst_req", 32'(ext_req), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_dout", data_out, 0);
        chk("rst_addr", 32'(ext_addr), 0);
        chk("rst_wdata", ext_wdata, 0);
        tick();
        chk("idle_req", 32'(ext_req), 0);

        // Write, acked 3 cycles after ext_req rises
        sel = 1; we = 1; addr = 10'h005; data_in = 32'hCAFEF00D;
        tick();
        chk("wr_req", 32'(ext_req), 1);
        chk("wr_we", 32'(ext_we), 1);
        chk("wr_addr", 32'(ext_addr), 32'h5);
        chk("wr_wdata", ext_wdata, 32'hCAFEF00D);
        tick(); tick();
        chk("wr_wait_ready", 32'(ready), 0);
        chk("wr_wait_req", 32'(ext_req), 1);
        tick();
        ext_ack = 1;
        tick();
        ext_ack = 0; sel = 0;
        chk("wr_ready", 32'(ready), 1);
        chk("wr_req_drop", 32'(ext_req), 0);
        chk("wr_err", 32'(err), 0);
        chk("wr_dout_kept", data_out, 0);
        tick();
        chk("wr_ready_once", 32'(ready), 0);

        // Read with immediate ack; an ack while idle must be ignored
        sel = 1; we = 0; addr = 10'h3FF; ext_rdata = 32'h12345678; ext_ack = 1;
        tick();
        chk("rd_req", 32'(ext_req), 1);
        chk("rd_we", 32'(ext_we), 0);
        chk("rd_addr", 32'(ext_addr), 32'h3FF);
        chk("rd_ready_early", 32'(ready), 0);
        tick();
        ext_ack = 0; sel = 0;
        chk("rd_ready", 32'(ready), 1);
        chk("rd_dout", data_out, 32'h12345678);
        tick();
        chk("rd_ready_once", 32'(ready), 0);
        chk("rd_dout_hold", data_out, 32'h12345678);

        // Timeout with no ack: req held for TIMEOUT+1 cycles
        sel = 1; we = 0; addr = 10'h001; ext_rdata = 32'hAAAA5555;
        tick();
        chk("to_req0", 32'(ext_req), 1);
        for (int i = 0; i < TO; i++) begin
            tick();
            chk("to_req_held", 32'(ext_req), 1);
            chk("to_no_ready", 32'(ready), 0);
        end
        tick();
        sel = 0;
        chk("to_req_drop", 32'(ext_req), 0);
        chk("to_ready", 32'(ready), 1);
        chk("to_dout", data_out, 0);
        chk("to_err", 32'(err), 1);
        tick();
        chk("to_err_sticky", 32'(err), 1);
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("to_err_clr", 32'(err), 0);

        // Ack and timeout in the same cycle: ack wins
        sel = 1; we = 0; addr = 10'h002; ext_rdata = 32'hDEADBEEF;
        tick();
        for (int i = 0; i < TO; i++) tick();
        ext_ack = 1;
        tick();
        ext_ack = 0; sel = 0;
        chk("race_ready", 32'(ready), 1);
        chk("race_dout", data_out, 32'hDEADBEEF);
        chk("race_err", 32'(err), 0);
        tick();

        // err_clr coinciding with a timeout: set wins
        sel = 1; we = 1; addr = 10'h003; data_in = 32'h0;
        tick();
        for (int i = 0; i < TO; i++) tick();
        err_clr = 1;
        tick();
        err_clr = 0; sel = 0;
        chk("clrset_err", 32'(err), 1);
        chk("clrset_dout_wr", data_out, 32'hDEADBEEF);
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("clrset_clr", 32'(err), 0);

        // Reset two cycles after ext_req rises; late ack ignored
        sel = 1; we = 1; addr = 10'h007; data_in = 32'h77777777;
        tick();
        chk("mid_req", 32'(ext_req), 1);
        tick(); tick();
        rst = 1;
        tick();
        rst = 0; sel = 0;
        chk("mid_req_drop", 32'(ext_req), 0);
        chk("mid_ready", 32'(ready), 0);
        chk("mid_addr", 32'(ext_addr), 0);
        ext_ack = 1;
        tick();
        chk("late_ack_req", 32'(ext_req), 0);
        chk("late_ack_ready", 32'(ready), 0);
        ext_ack = 0;
        tick();
        chk("late_ack_ready2", 32'(ready), 0);

        // Back-to-back accesses; inputs toggled while busy
        r0 = n_ready; q0 = n_rise;
        sel = 1; we = 1; addr = 10'h010; data_in = 32'h11111111;
        tick();
        addr = 10'h020; data_in = 32'h22222222; we = 0;
        tick();
        chk("b2b_addr_held", 32'(ext_addr), 32'h10);
        chk("b2b_wdata_held", ext_wdata, 32'h11111111);
        chk("b2b_we_held", 32'(ext_we), 1);
        ext_ack = 1;
        tick();
        ext_ack = 0;
        chk("b2b_ready1", 32'(ready), 1);
        tick();
        sel = 0;
        tick();
        sel = 1; we = 0; addr = 10'h030; ext_rdata = 32'h44444444;
        tick();
        chk("b2b_addr2", 32'(ext_addr), 32'h30);
        ext_ack = 1;
        tick();
        ext_ack = 0; sel = 0;
        chk("b2b_ready2", 32'(ready), 1);
        chk("b2b_dout2", data_out, 32'h44444444);
        tick(); tick();
        chk("b2b_rises", 32'(n_rise - q0), 2);
        chk("b2b_readies", 32'(n_ready - r0), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
